// File: rtl/clk_div_multi.sv
// NCH independent programmable clock-divider channels sharing one system clock.
// Each channel toggles a registered clk_out every De cycles and strobes tick on each rising toggle.
module clk_div_multi #(
  parameter int NCH     = 4,
  parameter int CW      = 16,
  parameter int DEF_DIV = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH*CW-1:0] div_val,
  input  logic [NCH-1:0]    div_load,
  input  logic              sync_clear,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    pending
);

  localparam logic [CW-1:0] DEF_DIV_C = CW'(DEF_DIV);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] div_q, div_d;
      logic [CW-1:0] shd_q, shd_d;
      logic          pend_q, pend_d;
      logic          clk_q, clk_d;
      logic          tick_q, tick_d;
      logic [CW-1:0] de;
      logic          wrap;

      // A zero divisor behaves as one; ">=" keeps cnt in range after a divisor shrink.
      assign de   = (div_q == '0) ? ONE_C : div_q;
      assign wrap = (cnt_q >= (de - ONE_C));

      always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sync_clear) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (pend_q) begin
            div_d  = shd_q;
            pend_d = 1'b0;
          end
        end else begin
          if (enable[gi]) begin
            cnt_d = wrap ? '0 : (cnt_q + ONE_C);
            if (cnt_q == '0) begin
              clk_d  = ~clk_q;
              tick_d = ~clk_q;
            end
            if (wrap && pend_q) begin
              div_d  = shd_q;
              pend_d = 1'b0;
            end
          end else if (pend_q) begin
            div_d  = shd_q;
            pend_d = 1'b0;
          end
          // A load on the apply edge becomes the next pending value.
          if (div_load[gi]) begin
            shd_d  = div_val[gi*CW +: CW];
            pend_d = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q  <= '0;
          div_q  <= DEF_DIV_C;
          shd_q  <= DEF_DIV_C;
          pend_q <= 1'b0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          div_q  <= div_d;
          shd_q  <= shd_d;
          pend_q <= pend_d;
          clk_q  <= clk_d;
          tick_q <= tick_d;
        end
      end

      assign clk_out[gi] = clk_q;
      assign tick[gi]    = tick_q;
      assign pending[gi] = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed table-driven bench for clk_div_multi; one line printed per checked transaction.
module tb_clk_div_multi;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    enable;
  logic [NCH*CW-1:0] div_val;
  logic [NCH-1:0]    div_load;
  logic              sync_clear;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    pending;

  clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_val(div_val),
    .div_load(div_load), .sync_clear(sync_clear),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  ld;
    logic [15:0] dv;
    logic        sc;
    logic        rst;
    logic [3:0]  ec;
    logic [3:0]  et;
    logic [3:0]  ep;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic rst, input logic [3:0] en, input logic [3:0] ld,
                     input logic [15:0] dv, input logic sc,
                     input logic [3:0] ec, input logic [3:0] et, input logic [3:0] ep);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.dv = dv; v.sc = sc;
    v.ec = ec; v.et = et; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic idle();
    enable = '0; div_load = '0; div_val = '0; sync_clear = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_clk", -1, clk_out, 4'h0);
    check("rst_tick", -1, tick, 4'h0);
    check("rst_pend", -1, pending, 4'h0);
    reset = 1'b1;
  endtask

  task automatic run_seg(input int lo, input int hi, input bit skip_rst);
    for (int i = lo; i < hi; i++) begin
      if (tbl[i].rst && !skip_rst) do_reset();
      enable = tbl[i].en; div_load = tbl[i].ld; div_val = {NCH{tbl[i].dv}};
      sync_clear = tbl[i].sc;
      @(posedge clk); #1;
      $display("vec %0d en=%h ld=%h dv=%0d sc=%b -> clk=%h tick=%h pend=%h",
               i, tbl[i].en, tbl[i].ld, tbl[i].dv, tbl[i].sc, clk_out, tick, pending);
      check("clk_out", i, clk_out, tbl[i].ec);
      check("tick", i, tick, tbl[i].et);
      check("pending", i, pending, tbl[i].ep);
    end
    idle();
  endtask

  int s1, s2, s3, s4, s5, s6;

  initial begin
    reset = 1'b1;
    idle();

    // Default D=5 on channel 0: rise 1, fall 6, rise 11.
    s1 = tbl.size();
    add(1, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0);
    for (int k = 2; k <= 5; k++) add(0, 4'h1, 4'h0, 0, 0, 4'h1, 4'h0, 4'h0);
    for (int k = 6; k <= 10; k++) add(0, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0);
    add(0, 4'h1, 4'h0, 0, 0, 4'h1, 4'h0, 4'h0);

    // Channel 1: load 3 at cnt=2; old half-period of 5 completes.
    s2 = tbl.size();
    add(1, 4'h2, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h0, 4'h0);
    add(0, 4'h2, 4'h2, 3, 0, 4'h2, 4'h0, 4'h2);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h0, 4'h2);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0);

    // D=0 on ch2, D=1 on ch3, applied while disabled: both toggle every cycle.
    s3 = tbl.size();
    add(1, 4'h0, 4'h4, 0, 0, 4'h0, 4'h0, 4'h4);
    add(0, 4'h0, 4'h8, 1, 0, 4'h0, 4'h0, 4'h8);
    add(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hC, 4'h0, 0, 0, 4'hC, 4'hC, 4'h0);
    add(0, 4'hC, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hC, 4'h0, 0, 0, 4'hC, 4'hC, 4'h0);
    add(0, 4'hC, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Ch2 frozen 7 cycles at cnt=1, then the remaining 4 counts complete.
    s4 = tbl.size();
    add(1, 4'h4, 4'h0, 0, 0, 4'h4, 4'h4, 4'h0);
    for (int k = 0; k < 7; k++) add(0, 4'h0, 4'h0, 0, 0, 4'h4, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) add(0, 4'h4, 4'h0, 0, 0, 4'h4, 4'h0, 4'h0);
    add(0, 4'h4, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);

    // D=3/4/7 free-running, then sync_clear realigns and applies a pending D=2 on ch0.
    s5 = tbl.size();
    add(1, 4'h0, 4'h1, 3, 0, 4'h0, 4'h0, 4'h1);
    add(0, 4'h0, 4'h2, 4, 0, 4'h0, 4'h0, 4'h2);
    add(0, 4'h0, 4'h4, 7, 0, 4'h0, 4'h0, 4'h4);
    add(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h7, 4'h7, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h7, 4'h0, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h7, 4'h0, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h6, 4'h0, 4'h0);
    add(0, 4'h7, 4'h1, 2, 0, 4'h4, 4'h0, 4'h1);
    add(0, 4'h7, 4'h0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h7, 4'h7, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h7, 4'h0, 4'h0);
    add(0, 4'h7, 4'h0, 0, 0, 4'h6, 4'h0, 4'h0);
    s6 = tbl.size();

    run_seg(s1, s2, 0);
    run_seg(s2, s3, 0);
    run_seg(s3, s4, 0);
    run_seg(s4, s5, 0);
    run_seg(s5, s6, 0);

    // Async reset between edges while ch0 runs at D=2 and ch1 holds a pending load.
    do_reset();
    div_load = 4'h1; div_val = {NCH{16'd2}};
    @(posedge clk); #1;
    check("ar_pend_a", -2, pending, 4'h1);
    idle();
    @(posedge clk); #1;
    check("ar_pend_b", -2, pending, 4'h0);
    enable = 4'h1;
    @(posedge clk); #1;
    check("ar_rise", -2, {tick[0], clk_out[0]}, 4'h3);
    div_load = 4'h2; div_val = {NCH{16'd9}};
    @(posedge clk); #1;
    check("ar_hold", -2, clk_out, 4'h1);
    check("ar_pend_c", -2, pending, 4'h2);
    idle();
    #2 reset = 1'b0;
    #1;
    $display("async reset mid-period -> clk=%h tick=%h pend=%h", clk_out, tick, pending);
    check("ar_clk", -2, clk_out, 4'h0);
    check("ar_pend", -2, pending, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_seg(s1, s2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
